// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported word memory between the instruction
//                fetch port and the load/store port of the multi-cycle core.
//                One backend transaction in flight at a time; requests are
//                latched at grant. Misaligned and out-of-range accesses are
//                acked with an error and never reach the backend.
//                Optional macro ARB_RR_EN selects round-robin tie breaking;
//                without it, data has fixed priority with a starvation guard
//                that hands the port to fetch after STARVE_MAX data grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int DEPTH      = 4096,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  // load/store port
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [31:0]              d_addr,
  input  logic [31:0]              d_wdata,
  output logic [31:0]              d_rdata,
  output logic                     d_ack,
  output logic                     d_err,
  // instruction fetch port
  input  logic                     i_req,
  input  logic [31:0]              i_addr,
  output logic [31:0]              i_rdata,
  output logic                     i_ack,
  output logic                     i_err,
  // memory backend
  output logic                     m_en,
  output logic                     m_we,
  output logic [$clog2(DEPTH)-1:0] m_addr,
  output logic [31:0]              m_wdata,
  input  logic [31:0]              m_rdata,
  input  logic                     m_done,
  // status
  output logic                     busy,
  output logic                     grant_i
);

  localparam int          ADDR_W     = $clog2(DEPTH);
  // First byte address past the end of memory, one bit wider than the bus so
  // the comparison stays correct even if DEPTH*4 reaches 2**32.
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      state;
  logic        txn_we;         // latched write flag of the owning transaction

  logic        d_ok;           // data request is aligned and in range
  logic        i_ok;           // fetch request is aligned and in range
  logic        fetch_wins_tie; // tie-break decision from the selected policy
  logic        pick_i;         // fetch is the port granted this cycle
  logic        sel_ok;         // the selected request may go to the backend
  logic [31:0] sel_addr;
  logic        grant_evt;      // a grant (valid or not) happens this cycle

  // --------------------------------------------------------------------------
  // Request checks: word alignment and byte range for each port
  // --------------------------------------------------------------------------
  always_comb begin
    d_ok = (d_addr[1:0] == 2'b00) && ({1'b0, d_addr} < BYTE_LIMIT);
    i_ok = (i_addr[1:0] == 2'b00) && ({1'b0, i_addr} < BYTE_LIMIT);
  end

  // --------------------------------------------------------------------------
  // Port selection: a lone requester always wins, ties go to the policy
  // --------------------------------------------------------------------------
  always_comb begin
    pick_i = 1'b0;
    if (i_req && !d_req) begin
      pick_i = 1'b1;
    end else if (i_req && d_req) begin
      pick_i = fetch_wins_tie;
    end
    sel_addr = pick_i ? i_addr : d_addr;
    sel_ok   = pick_i ? i_ok   : d_ok;
  end

  assign grant_evt = (state == S_IDLE) && (d_req || i_req);

`ifdef ARB_RR_EN
  // High when fetch should win the next tie. Starts low so data takes the
  // first tie after reset; flips to the other port on every grant, including
  // grants of invalid requests.
  logic rr_prio_i;

  // Round-robin pointer update on each grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_prio_i <= 1'b0;
    end else if (grant_evt) begin
      rr_prio_i <= ~pick_i;
    end
  end

  assign fetch_wins_tie = rr_prio_i;
`else
  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  // Number of consecutive data grants made while fetch was also waiting.
  logic [3:0] starve_cnt;

  // Starvation counter: count data grants that bypass a waiting fetch,
  // clear whenever fetch is granted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else if (grant_evt) begin
      if (pick_i) begin
        starve_cnt <= 4'd0;
      end else if (i_req && (starve_cnt != STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  assign fetch_wins_tie = (starve_cnt == STARVE_LIMIT);
`endif

  // --------------------------------------------------------------------------
  // Transaction FSM: grant, one-cycle backend strobe, wait for completion,
  // one-cycle ack to the owner. Every output is driven from a register.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      txn_we  <= 1'b0;
      busy    <= 1'b0;
      grant_i <= 1'b0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= 32'h0;
      d_rdata <= 32'h0;
      d_ack   <= 1'b0;
      d_err   <= 1'b0;
      i_rdata <= 32'h0;
      i_ack   <= 1'b0;
      i_err   <= 1'b0;
    end else begin
      // strobes and acks are single-cycle pulses
      m_en  <= 1'b0;
      m_we  <= 1'b0;
      d_ack <= 1'b0;
      i_ack <= 1'b0;

      case (state)
        S_IDLE: begin
          if (d_req || i_req) begin
            busy    <= 1'b1;
            grant_i <= pick_i;
            txn_we  <= ~pick_i & d_we;
            if (sel_ok) begin
              // Latch everything the backend needs so later input changes
              // on the requesting port cannot disturb the transaction.
              state   <= S_ISSUE;
              m_en    <= 1'b1;
              m_we    <= ~pick_i & d_we;
              m_addr  <= sel_addr[ADDR_W+1:2];
              m_wdata <= pick_i ? 32'h0 : d_wdata;
            end else begin
              // Bad address: answer straight away, backend stays quiet.
              state <= S_RESP;
              if (pick_i) begin
                i_ack   <= 1'b1;
                i_err   <= 1'b1;
                i_rdata <= 32'h0;
              end else begin
                d_ack   <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= 32'h0;
              end
            end
          end
        end

        S_ISSUE: begin
          // m_done cannot legally arrive while the strobe is up.
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (m_done) begin
            state <= S_RESP;
            if (grant_i) begin
              i_ack   <= 1'b1;
              i_err   <= 1'b0;
              i_rdata <= m_rdata;
            end else begin
              d_ack   <= 1'b1;
              d_err   <= 1'b0;
              // stores return zero rather than whatever the backend drives
              d_rdata <= txn_we ? 32'h0 : m_rdata;
            end
          end
        end

        S_RESP: begin
          // Ack pulse ends here; return data and error only live with it.
          state   <= S_IDLE;
          busy    <= 1'b0;
          d_rdata <= 32'h0;
          d_err   <= 1'b0;
          i_rdata <= 32'h0;
          i_err   <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed vector table for single transactions plus
//                hand-written sequences for ties, starvation, slow backend
//                and reset in the middle of a transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int DEPTH = 4096;
  localparam int AW    = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          d_req, d_we;
  logic [31:0]   d_addr, d_wdata, d_rdata;
  logic          d_ack, d_err;
  logic          i_req;
  logic [31:0]   i_addr, i_rdata;
  logic          i_ack, i_err;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata, m_rdata;
  logic          m_done;
  logic          busy, grant_i;

  logic          be_done = 1'b0;
  logic          force_done = 1'b0;
  logic [31:0]   be_rdata = 32'h0;

  assign m_done  = be_done | force_done;
  assign m_rdata = be_rdata;

  mem_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done),
    .busy(busy), .grant_i(grant_i)
  );

  always #5 clk = ~clk;

  // ---------------- event recording and backend model ----------------
  typedef struct {
    int            cyc;
    logic          fetch;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } men_t;

  typedef struct {
    int          cyc;
    logic        fetch;
    logic [31:0] rdata;
    logic        err;
  } ack_t;

  men_t        men_q[$];
  ack_t        ack_q[$];
  men_t        men_e;
  ack_t        ack_e;
  int          cyc = 0;
  int          overlap = 0;
  int          be_delay = 1;
  int          be_cnt = 0;
  logic        be_pend = 1'b0;
  logic [31:0] be_data = 32'h0;

  // Record strobes/acks just after each edge and answer m_en after be_delay cycles.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (m_en) begin
      men_e.cyc = cyc; men_e.fetch = grant_i; men_e.we = m_we;
      men_e.addr = m_addr; men_e.wdata = m_wdata;
      men_q.push_back(men_e);
    end
    if (d_ack) begin
      ack_e.cyc = cyc; ack_e.fetch = 1'b0; ack_e.rdata = d_rdata; ack_e.err = d_err;
      ack_q.push_back(ack_e);
    end
    if (i_ack) begin
      ack_e.cyc = cyc; ack_e.fetch = 1'b1; ack_e.rdata = i_rdata; ack_e.err = i_err;
      ack_q.push_back(ack_e);
    end
    if (m_en && (d_ack || i_ack)) overlap++;
    be_done  = 1'b0;
    be_rdata = 32'h0;
    if (!reset) begin
      be_pend = 1'b0;
    end else if (m_en) begin
      be_pend = 1'b1;
      be_cnt  = be_delay;
    end else if (be_pend) begin
      be_cnt--;
      if (be_cnt <= 0) begin
        be_done  = 1'b1;
        be_rdata = be_data;
        be_pend  = 1'b0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " flags"}, {24'h0, d_ack, d_err, i_ack, i_err, m_en, m_we, busy, grant_i}, 32'h0);
    check({tag, " m_addr"}, {20'h0, m_addr}, 32'h0);
    check({tag, " m_wdata"}, m_wdata, 32'h0);
    check({tag, " d_rdata"}, d_rdata, 32'h0);
    check({tag, " i_rdata"}, i_rdata, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; d_req = 1'b0; i_req = 1'b0; force_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic clear_log(output int t0, output int ov0);
    men_q.delete();
    ack_q.delete();
    t0  = cyc;
    ov0 = overlap;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          fetch;
    logic          we;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   be_rdata;
    int            dly;
    int            exp_lat;
    int            exp_men;
    logic [AW-1:0] exp_maddr;
    logic [31:0]   exp_rdata;
    logic          exp_err;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  initial begin
    int          t0, ov0;
    logic [5:0]  exp_order, act_order;

    reset = 1'b0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    i_req = 1'b0; i_addr = 32'h0;

    //          fetch we    addr          wdata         backend       dly lat men maddr   rdata         err
    vecs[0]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,        32'h1234_5678, 1, 3, 1, 12'd4,    32'h1234_5678, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h5555_5555, 1, 3, 1, 12'd2,    32'h0,         1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,        32'h8C01_0004, 2, 4, 1, 12'd3072, 32'h8C01_0004, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0000_0006, 32'h0,        32'hBAD0_BAD0, 1, 1, 0, 12'd0,    32'h0,         1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_4000, 32'h0,        32'hBAD0_BAD0, 1, 1, 0, 12'd0,    32'h0,         1'b1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0000_2FFC, 32'h0,        32'hA5A5_5A5A, 3, 5, 1, 12'd3071, 32'hA5A5_5A5A, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_4000, 32'h0000_0001, 32'hBAD0_BAD0, 1, 1, 0, 12'd0,    32'h0,         1'b1};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_3002, 32'h0,        32'hBAD0_BAD0, 1, 1, 0, 12'd0,    32'h0,         1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0,        32'hBAD0_BAD0, 1, 1, 0, 12'd0,    32'h0,         1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0077, 4, 6, 1, 12'd0,    32'h0,         1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_3FFC, 32'h0,        32'h0000_0013, 1, 3, 1, 12'd4095, 32'h0000_0013, 1'b0};

    // reset state
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    check_zero("post_reset_idle");

    // single transactions from the table
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      clear_log(t0, ov0);
      be_delay = vecs[k].dly;
      be_data  = vecs[k].be_rdata;
      if (vecs[k].fetch) begin
        i_req = 1'b1; i_addr = vecs[k].addr;
      end else begin
        d_req = 1'b1; d_we = vecs[k].we; d_addr = vecs[k].addr; d_wdata = vecs[k].wdata;
      end
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (d_ack) d_req = 1'b0;
        if (i_ack) i_req = 1'b0;
      end
      d_req = 1'b0; i_req = 1'b0;
      check($sformatf("v%0d ack_count", k), ack_q.size(), 1);
      check($sformatf("v%0d men_count", k), men_q.size(), vecs[k].exp_men);
      check($sformatf("v%0d overlap", k), overlap - ov0, 0);
      if (ack_q.size() >= 1) begin
        check($sformatf("v%0d ack_port", k), {31'h0, ack_q[0].fetch}, {31'h0, vecs[k].fetch});
        check($sformatf("v%0d ack_lat", k), ack_q[0].cyc - t0, vecs[k].exp_lat);
        check($sformatf("v%0d rdata", k), ack_q[0].rdata, vecs[k].exp_rdata);
        check($sformatf("v%0d err", k), {31'h0, ack_q[0].err}, {31'h0, vecs[k].exp_err});
      end
      if (vecs[k].exp_men == 1 && men_q.size() >= 1) begin
        check($sformatf("v%0d m_addr", k), {20'h0, men_q[0].addr}, {20'h0, vecs[k].exp_maddr});
        check($sformatf("v%0d m_we", k), {31'h0, men_q[0].we}, {31'h0, vecs[k].we});
        check($sformatf("v%0d grant_i", k), {31'h0, men_q[0].fetch}, {31'h0, vecs[k].fetch});
        if (vecs[k].we)
          check($sformatf("v%0d m_wdata", k), men_q[0].wdata, vecs[k].wdata);
      end
    end

    // store and fetch raised together: store first, fetch two cycles after d_ack
    do_reset();
    @(negedge clk);
    clear_log(t0, ov0);
    be_delay = 1; be_data = 32'h0BAD_C0DE;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'hDEAD_BEEF;
    i_req = 1'b1; i_addr = 32'h3000;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (d_ack) d_req = 1'b0;
      if (i_ack) i_req = 1'b0;
    end
    d_req = 1'b0; i_req = 1'b0;
    check("tie men_count", men_q.size(), 2);
    check("tie ack_count", ack_q.size(), 2);
    if (men_q.size() >= 2) begin
      check("tie first_port", {31'h0, men_q[0].fetch}, 32'h0);
      check("tie first_addr", {20'h0, men_q[0].addr}, 32'd2);
      check("tie first_we", {31'h0, men_q[0].we}, 32'h1);
      check("tie first_wdata", men_q[0].wdata, 32'hDEAD_BEEF);
      check("tie second_port", {31'h0, men_q[1].fetch}, 32'h1);
      check("tie second_addr", {20'h0, men_q[1].addr}, 32'd3072);
      check("tie second_we", {31'h0, men_q[1].we}, 32'h0);
    end
    if (ack_q.size() >= 2 && men_q.size() >= 2) begin
      check("tie d_ack_lat", ack_q[0].cyc - t0, 3);
      check("tie d_rdata", ack_q[0].rdata, 32'h0);
      check("tie ack_to_men", men_q[1].cyc - ack_q[0].cyc, 2);
      check("tie i_ack_lat", ack_q[1].cyc - t0, 7);
      check("tie i_rdata", ack_q[1].rdata, 32'h0BAD_C0DE);
      check("tie i_port", {31'h0, ack_q[1].fetch}, 32'h1);
    end
    check("tie overlap", overlap - ov0, 0);

    // both ports held high: grant order
    do_reset();
    @(negedge clk);
    clear_log(t0, ov0);
    be_delay = 1; be_data = 32'h0000_1111;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    i_req = 1'b1; i_addr = 32'h3004;
    repeat (26) @(negedge clk);
    d_req = 1'b0; i_req = 1'b0;
    repeat (8) @(negedge clk);
`ifdef ARB_RR_EN
    exp_order = 6'b101010;
`else
    exp_order = 6'b010000;
`endif
    check("starve enough_grants", {31'h0, men_q.size() >= 6}, 32'h1);
    if (men_q.size() >= 6) begin
      for (int g = 0; g < 6; g++) act_order[g] = men_q[g].fetch;
      check("starve order", {26'h0, act_order}, {26'h0, exp_order});
    end
    check("starve overlap", overlap - ov0, 0);

    // slow backend, inputs change and request drops during WAIT
    do_reset();
    @(negedge clk);
    clear_log(t0, ov0);
    be_delay = 5; be_data = 32'hCAFE_F00D;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h1111_2222;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 3) begin
        d_addr = 32'h88; d_wdata = 32'h3333_4444; d_we = 1'b0; d_req = 1'b0;
      end
      if (d_ack) d_req = 1'b0;
    end
    check("slow men_count", men_q.size(), 1);
    check("slow ack_count", ack_q.size(), 1);
    if (men_q.size() >= 1) begin
      check("slow m_addr", {20'h0, men_q[0].addr}, 32'd17);
      check("slow m_wdata", men_q[0].wdata, 32'h1111_2222);
      check("slow m_we", {31'h0, men_q[0].we}, 32'h1);
    end
    if (ack_q.size() >= 1) begin
      check("slow ack_lat", ack_q[0].cyc - t0, 7);
      check("slow rdata", ack_q[0].rdata, 32'h0);
      check("slow err", {31'h0, ack_q[0].err}, 32'h0);
    end
    check("slow held_m_addr", {20'h0, m_addr}, 32'd17);
    check("slow held_m_wdata", m_wdata, 32'h1111_2222);

    // reset during WAIT, then a stray m_done
    @(negedge clk);
    clear_log(t0, ov0);
    be_delay = 5; be_data = 32'h0000_0099;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    repeat (3) @(negedge clk);
    check("rst_wait busy_before", {31'h0, busy}, 32'h1);
    reset = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check_zero("rst_wait");
    reset = 1'b1; force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_wait late_ack", ack_q.size(), 0);
    check("rst_wait men_count", men_q.size(), 1);
    check("rst_wait busy_after", {31'h0, busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-ported word memory between the instruction-fetch port and the load/store (lw/sw) port of the multi-cycle MIPS core. It sits between the core's IF/MEM stages and the unified memory backend (code at byte 0x3000 upward, data below). It serialises accesses, tracks one outstanding backend transaction, and returns data/ack to the owning port. Error checks cover alignment and range.

## Interface
- DEPTH, 4096: memory size in 32-bit words; valid byte addresses 0 .. DEPTH*4-1.
- STARVE_MAX, 4: maximum consecutive data grants while fetch waits (fixed-priority mode); range 1..15.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; one clock domain.
- d_req  in  1  data-port request; held until d_ack.
- d_we  in  1  1 = store (sw), 0 = load (lw).
- d_addr  in  32  byte address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data; valid while d_ack=1.
- d_ack  out  1  one-cycle completion pulse.
- d_err  out  1  valid with d_ack: misaligned or out-of-range.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  32  fetch byte address (pc).
- i_rdata  out  32  instruction word; valid while i_ack=1.
- i_ack  out  1  one-cycle completion pulse.
- i_err  out  1  valid with i_ack.
- m_en  out  1  one-cycle backend strobe.
- m_we  out  1  backend write enable, valid with m_en.
- m_addr  out  log2(DEPTH)  word index = addr[log2(DEPTH)+1:2].
- m_wdata  out  32  backend write data.
- m_rdata  in  32  backend read data, valid with m_done.
- m_done  in  1  backend completion; earliest the cycle after m_en.
- busy  out  1  state != IDLE.
- grant_i  out  1  current/last owner is fetch port.

## Operation
- FSM states:
  - IDLE -> ISSUE on a granted valid request.
  - IDLE -> RESP on a granted invalid request, with err=1 and no m_en.
  - ISSUE: m_en=1 for exactly one cycle -> WAIT.
  - WAIT: stays until m_done is sampled high; m_rdata is latched -> RESP.
  - RESP: the owner's ack=1 for one cycle -> IDLE.
- Arbitration happens only in IDLE. The request, addr, we and wdata are latched at grant, so later input changes do not affect the transaction.
- Priority (default): data wins ties. A starvation counter increments on each data grant made while i_req=1 and clears on any fetch grant. When the counter equals STARVE_MAX and i_req=1, fetch wins.
- Invalid request: addr[1:0]!=0, or addr >= DEPTH*4. It is acked with err=1, rdata=0, and the backend is untouched.
- Stores: the ack carries rdata=0. Fetch never writes; m_we=0 for fetch grants.
- A requester dropping req before its ack does not abort the transaction; the ack still pulses.
- m_done outside WAIT is ignored.

## Timing
- Reset (async assert, sync release) gives state=IDLE and all outputs 0: m_en, m_we, m_addr, m_wdata, d_*/i_* outputs, busy, grant_i. The starvation counter and RR pointer are also 0.
- Reset mid-transaction returns to IDLE immediately. A backend response still in flight is dropped.
- Cycle numbering: edge n samples the request in IDLE.
  - m_en is high in cycle n+1.
  - If m_done is high in cycle n+2, ack is high in cycle n+3.
  - Minimum latency req->ack is 3 cycles; each extra backend wait cycle adds 1.
  - An invalid request is acked in cycle n+1.
- After ack, state is IDLE in the next cycle. A held-high competing request is granted at that edge, which makes ack->next m_en 2 cycles.
- Throughput: at most one transaction in flight. ack and m_en are never high in the same cycle.

## Configuration
- ARB_RR_EN defined: round-robin arbitration. On a tie, the port not granted last wins; the pointer updates on every grant, including invalid ones. STARVE_MAX and the starvation counter are unused and held at 0.
- ARB_RR_EN undefined: fixed data priority with the STARVE_MAX starvation guard described above.

## Test plan
- Reset/idle: reset=0 mid-WAIT -> next cycle all outputs 0, busy=0. A late m_done=1 produces no ack.
- Single load: d_req, d_addr=0x0000_0010, backend m_done one cycle after m_en with m_rdata=0x1234_5678 -> m_addr=4, m_we=0, d_ack in cycle n+3 with d_rdata=0x1234_5678, d_err=0.
- Store then fetch tie: d_req (sw 0x8 <= 0xDEAD_BEEF) and i_req (0x3000) raised together -> the data store is issued first (m_we=1, m_addr=2), then the fetch is issued with m_addr=3072.
- Starvation (ARB_RR_EN undefined, STARVE_MAX=4): d_req and i_req held high -> grant order D,D,D,D,I,D,... Under ARB_RR_EN the order is D,I,D,I.
- Errors: d_addr=0x0000_0006 -> d_ack+d_err one cycle later, m_en never high. i_addr=0x4000 (DEPTH=4096) -> i_ack+i_err.
- Slow backend: m_done delayed 5 cycles, while d_addr/d_wdata are changed during WAIT -> the latched values are used, and exactly one ack is produced.
